// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared types, defaults and helpers for the memory I/O unit
package mem_io_pkg;

   // External bridge sequencing: accept in IDLE, hold the bus in WAIT, present result in DONE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } ext_state_e;

   localparam logic [15:0] EXT_BASE_DEFAULT    = 16'hF000;
   localparam int          EXT_TIMEOUT_DEFAULT = 15;

   // Byte loads are returned to the 12-bit datapath as signed values
   function automatic logic [11:0] sext8(input logic [7:0] b);
      return {{4{b[7]}}, b};
   endfunction

endpackage

// File: rtl/mem_io_unit_ext_bridge.sv
// rtl/mem_io_unit_ext_bridge.sv - req/ack bridge to the 8-bit peripheral bus with timeout
module ext_bus_bridge
   import mem_io_pkg::*;
#(
   parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        ext_sel,
   input  logic        is_write,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   input  logic [7:0]  ext_rdata,
   input  logic        ext_ack,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   output logic        ext_we,
   output logic        ext_req,
   output logic        mem_stall,
   output logic        bus_err,
   output logic        done_valid,
   output logic [7:0]  done_rdata
);

   localparam int                CNT_W    = $clog2(EXT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXT_TIMEOUT - 1);

   ext_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             we_q, we_d;
   logic             req_q, req_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             stall_c;

   // State and bus-side registers; everything except the RAMs returns to a known value on reset
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and stall: a new request is only taken from IDLE; ack beats a same-cycle timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      stall_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ext_sel) begin
               stall_c = 1'b1;
               addr_d  = address;
               wdata_d = wdata;
               we_d    = is_write;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall_c = 1'b1;
            if (ext_ack) begin
               rdata_d = we_q ? 8'h00 : ext_rdata;
               req_d   = 1'b0;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = 8'h00;
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_stall  = stall_c & nreset;
   assign ext_addr   = addr_q;
   assign ext_wdata  = wdata_q;
   assign ext_we     = we_q;
   assign ext_req    = req_q;
   assign bus_err    = err_q;
   assign done_valid = (state_q == ST_DONE);
   assign done_rdata = rdata_q;

endmodule

// File: rtl/mem_io_unit.sv
// rtl/mem_io_unit.sv - MEM-stage responder: data RAM, call-stack RAM and external bus bridge
module mem_io_unit
   import mem_io_pkg::*;
#(
   parameter int          DATA_ADDR_W = 10,
   parameter int          CSTK_DEPTH  = 256,
   parameter logic [15:0] EXT_BASE    = EXT_BASE_DEFAULT,
   parameter int          EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic [15:0] address,
   input  logic [7:0]  call_stack_ptr,
   input  logic        call_stk_sel,
   input  logic        mem_rden,
   input  logic        mem_wren,
   input  logic [11:0] mem_write_data,
   output logic [11:0] mem_read_data,
   output logic        mem_stall,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   output logic        ext_we,
   output logic        ext_req,
   input  logic [7:0]  ext_rdata,
   input  logic        ext_ack,
   output logic        bus_err
);

   logic [7:0]  data_ram [2**DATA_ADDR_W];
   logic [11:0] cstk_ram [CSTK_DEPTH];

   logic       data_hit;
   logic       ext_hit;
   logic       ext_sel;
   logic       data_we;
   logic       cstk_we;
   logic       done_valid;
   logic [7:0] done_rdata;
   logic [11:0] rd_data;

   assign data_hit = (address[15:DATA_ADDR_W] == '0);
   assign ext_hit  = (address >= EXT_BASE);
   assign ext_sel  = !call_stk_sel && ext_hit && (mem_rden || mem_wren);
   assign data_we  = nreset && mem_wren && !call_stk_sel && data_hit;
   assign cstk_we  = nreset && mem_wren && call_stk_sel;

   // Data RAM byte store; contents survive reset
   always_ff @(posedge clock) begin
      if (data_we) begin
         data_ram[address[DATA_ADDR_W-1:0]] <= mem_write_data[7:0];
      end
   end

   // Call-stack store of the full 12-bit word; contents survive reset
   always_ff @(posedge clock) begin
      if (cstk_we) begin
         cstk_ram[call_stack_ptr] <= mem_write_data;
      end
   end

   ext_bus_bridge #(
      .EXT_TIMEOUT (EXT_TIMEOUT)
   ) u_bridge (
      .clock      (clock),
      .nreset     (nreset),
      .ext_sel    (ext_sel),
      .is_write   (mem_wren),
      .address    (address),
      .wdata      (mem_write_data[7:0]),
      .ext_rdata  (ext_rdata),
      .ext_ack    (ext_ack),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_we     (ext_we),
      .ext_req    (ext_req),
      .mem_stall  (mem_stall),
      .bus_err    (bus_err),
      .done_valid (done_valid),
      .done_rdata (done_rdata)
   );

   // Read mux: the external result owns the DONE cycle; a write (even with rden) returns 0
   always_comb begin
      rd_data = '0;
      if (!nreset) begin
         rd_data = '0;
      end else if (done_valid) begin
         rd_data = sext8(done_rdata);
      end else if (mem_wren) begin
         rd_data = '0;
      end else if (mem_rden) begin
         if (call_stk_sel) begin
            rd_data = cstk_ram[call_stack_ptr];
         end else if (data_hit) begin
            rd_data = sext8(data_ram[address[DATA_ADDR_W-1:0]]);
         end
      end
   end

   assign mem_read_data = rd_data;

endmodule

// File: tb/tb_mem_io_unit.sv
// tb/tb_mem_io_unit.sv - directed self-checking bench for mem_io_unit
module tb_mem_io_unit;

   logic        clock = 1'b0;
   logic        nreset;
   logic [15:0] address;
   logic [7:0]  call_stack_ptr;
   logic        call_stk_sel;
   logic        mem_rden;
   logic        mem_wren;
   logic [11:0] mem_write_data;
   logic [11:0] mem_read_data;
   logic        mem_stall;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_we;
   logic        ext_req;
   logic [7:0]  ext_rdata;
   logic        ext_ack;
   logic        bus_err;

   int total  = 0;
   int passed = 0;
   int wait_cycles;

   mem_io_unit dut (
      .clock          (clock),
      .nreset         (nreset),
      .address        (address),
      .call_stack_ptr (call_stack_ptr),
      .call_stk_sel   (call_stk_sel),
      .mem_rden       (mem_rden),
      .mem_wren       (mem_wren),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_stall      (mem_stall),
      .ext_addr       (ext_addr),
      .ext_wdata      (ext_wdata),
      .ext_we         (ext_we),
      .ext_req        (ext_req),
      .ext_rdata      (ext_rdata),
      .ext_ack        (ext_ack),
      .bus_err        (bus_err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      nreset = 1'b0; address = 16'h0010; call_stack_ptr = 8'h00; call_stk_sel = 1'b0;
      mem_rden = 1'b1; mem_wren = 1'b0; mem_write_data = 12'h000;
      ext_rdata = 8'h00; ext_ack = 1'b0;
      step(); step();
      chk("rst_ext_req", 16'(ext_req), 16'h0);
      chk("rst_stall", 16'(mem_stall), 16'h0);
      chk("rst_bus_err", 16'(bus_err), 16'h0);
      chk("rst_ext_addr", ext_addr, 16'h0000);
      chk("rst_ext_wdata", 16'(ext_wdata), 16'h0);
      chk("rst_ext_we", 16'(ext_we), 16'h0);
      chk("rst_rdata", 16'(mem_read_data), 16'h0);
      nreset = 1'b1; mem_rden = 1'b0;

      // data RAM: negative byte sign-extends, positive byte does not
      mem_wren = 1'b1; mem_write_data = 12'h0A5; step();
      mem_wren = 1'b0; mem_rden = 1'b1; #1;
      chk("ram_rd_a5", 16'(mem_read_data), 16'h0FA5);
      chk("ram_rd_stall", 16'(mem_stall), 16'h0);
      mem_rden = 1'b0; mem_wren = 1'b1; mem_write_data = 12'h07F; step();
      mem_wren = 1'b0; mem_rden = 1'b1; #1;
      chk("ram_rd_7f", 16'(mem_read_data), 16'h007F);
      mem_rden = 1'b0;

      // call stack: address points into external space but must be ignored
      call_stk_sel = 1'b1; call_stack_ptr = 8'h03; address = 16'hF004;
      mem_wren = 1'b1; mem_write_data = 12'hABC; #1;
      chk("cstk_wr_stall", 16'(mem_stall), 16'h0);
      step();
      chk("cstk_no_req", 16'(ext_req), 16'h0);
      mem_wren = 1'b0; mem_rden = 1'b1; #1;
      chk("cstk_rd", 16'(mem_read_data), 16'h0ABC);
      mem_rden = 1'b0; call_stk_sel = 1'b0;

      // simultaneous rden+wren: write wins, read data 0
      address = 16'h0020; mem_rden = 1'b1; mem_wren = 1'b1; mem_write_data = 12'h055; #1;
      chk("rdwr_rdata0", 16'(mem_read_data), 16'h0);
      step();
      mem_wren = 1'b0; #1;
      chk("rdwr_later_rd", 16'(mem_read_data), 16'h0055);
      mem_rden = 1'b0;

      // unmapped hole: write dropped, read 0, no stall
      address = 16'h8000; mem_wren = 1'b1; mem_write_data = 12'h011; step();
      mem_wren = 1'b0; mem_rden = 1'b1; #1;
      chk("unmap_rd", 16'(mem_read_data), 16'h0);
      chk("unmap_stall", 16'(mem_stall), 16'h0);
      mem_rden = 1'b0;

      // ack outside WAIT is ignored
      ext_ack = 1'b1; ext_rdata = 8'h55; step();
      chk("stray_ack_req", 16'(ext_req), 16'h0);
      ext_ack = 1'b0;

      // external read with ack on the second WAIT cycle: three stalled cycles
      address = 16'hF004; mem_rden = 1'b1; #1;
      chk("xrd_idle_stall", 16'(mem_stall), 16'h1);
      step();
      chk("xrd_req", 16'(ext_req), 16'h1);
      chk("xrd_addr", ext_addr, 16'hF004);
      chk("xrd_we", 16'(ext_we), 16'h0);
      chk("xrd_wait1_stall", 16'(mem_stall), 16'h1);
      step();
      chk("xrd_wait2_stall", 16'(mem_stall), 16'h1);
      ext_ack = 1'b1; ext_rdata = 8'h80; step();
      ext_ack = 1'b0; ext_rdata = 8'h00; #1;
      chk("xrd_done_stall", 16'(mem_stall), 16'h0);
      chk("xrd_done_req", 16'(ext_req), 16'h0);
      chk("xrd_done_rdata", 16'(mem_read_data), 16'h0F80);
      step();
      chk("xrd_no_reissue", 16'(ext_req), 16'h0);
      chk("xrd_idle_restall", 16'(mem_stall), 16'h1);
      mem_rden = 1'b0; #1;
      chk("xrd_idle_free", 16'(mem_stall), 16'h0);

      // external write that times out after 15 WAIT cycles
      address = 16'hF100; mem_wren = 1'b1; mem_write_data = 12'h03C; step();
      chk("xwr_req", 16'(ext_req), 16'h1);
      chk("xwr_we", 16'(ext_we), 16'h1);
      chk("xwr_addr", ext_addr, 16'hF100);
      chk("xwr_wdata", 16'(ext_wdata), 16'h003C);
      wait_cycles = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (ext_req !== 1'b1) break;
         wait_cycles++;
      end
      chk("tmo_wait_cycles", 16'(wait_cycles), 16'd15);
      chk("tmo_bus_err", 16'(bus_err), 16'h1);
      chk("tmo_done_stall", 16'(mem_stall), 16'h0);
      chk("tmo_done_rdata", 16'(mem_read_data), 16'h0);
      mem_wren = 1'b0; step(); step();
      chk("tmo_err_sticky", 16'(bus_err), 16'h1);

      // reset in the middle of WAIT
      address = 16'hF300; mem_rden = 1'b1; step();
      chk("rstmid_req_before", 16'(ext_req), 16'h1);
      nreset = 1'b0; #1;
      chk("rstmid_stall_low", 16'(mem_stall), 16'h0);
      step();
      chk("rstmid_req", 16'(ext_req), 16'h0);
      chk("rstmid_bus_err", 16'(bus_err), 16'h0);
      chk("rstmid_addr", ext_addr, 16'h0000);
      mem_rden = 1'b0; nreset = 1'b1;
      address = 16'h0010; mem_rden = 1'b1; #1;
      chk("rstmid_ram_keep", 16'(mem_read_data), 16'h007F);
      chk("rstmid_idle_stall", 16'(mem_stall), 16'h0);
      call_stk_sel = 1'b1; call_stack_ptr = 8'h03; #1;
      chk("rstmid_cstk_keep", 16'(mem_read_data), 16'h0ABC);
      call_stk_sel = 1'b0; mem_rden = 1'b0;

      // ack on the last WAIT cycle beats the timeout
      address = 16'hF200; mem_rden = 1'b1; step();
      repeat (14) step();
      chk("late_ack_req", 16'(ext_req), 16'h1);
      ext_ack = 1'b1; ext_rdata = 8'h12; step();
      ext_ack = 1'b0; #1;
      chk("late_ack_no_err", 16'(bus_err), 16'h0);
      chk("late_ack_rdata", 16'(mem_read_data), 16'h0012);
      chk("late_ack_req_drop", 16'(ext_req), 16'h0);
      mem_rden = 1'b0; step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
